// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard logic.
// The hazard FSM encoding is also visible on the debug state port.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LDUSE    = 2'd1,
    MEMWAIT  = 2'd2,
    REDIRECT = 2'd3
  } hz_state_t;

  localparam int DEF_REG_W = 6;

  // Register index 0 reads as constant zero and can never carry a hazard.
  localparam int ZERO_REG = 0;

endpackage : pipe_pkg

// File: rtl/hz_luse_cmp.sv
// Combinational load-use comparator: flags an ID-stage read of the register
// that a load currently in EX will write. Shared with the forwarding unit.
module hz_luse_cmp
  import pipe_pkg::*;
#(
  parameter int REG_W = DEF_REG_W
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_memrd,
  input  logic [REG_W-1:0] ex_rd,
  output logic             luse
);

  logic rd_live;
  logic rs_hit;
  logic rt_hit;

  assign rd_live = (ex_rd != REG_W'(ZERO_REG));
  assign rs_hit  = id_use_rs && (id_rs == ex_rd);
  assign rt_hit  = id_use_rt && (id_rt == ex_rd);
  assign luse    = ex_memrd && rd_live && (rs_hit || rt_hit);

endmodule : hz_luse_cmp

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline (redirect > mem wait > load-use).
// Define HAZARD_PERF_CNT_EN to add the stall_cnt / flush_cnt performance counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_W        = DEF_REG_W,
  parameter int FLUSH_CYCLES = 1
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int CNT_W        = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_memrd,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_memrd,
  input  logic             mem_memwrt,
  input  logic             dmem_ack,
  input  logic             wb_redirect,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_flush,
  output logic             pipe_freeze,
  output logic [1:0]       state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  hz_state_t  cur_state;
  hz_state_t  nxt_state;
  logic [1:0] fcnt;
  logic [1:0] nxt_fcnt;
  logic       luse;
  logic       mwait;
  logic       redirect_take;

  hz_luse_cmp #(
    .REG_W (REG_W)
  ) u_luse_cmp (
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .ex_memrd  (ex_memrd),
    .ex_rd     (ex_rd),
    .luse      (luse)
  );

  assign mwait = (mem_memrd || mem_memwrt) && !dmem_ack;
  assign state = cur_state;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= RUN;
      fcnt      <= 2'd0;
    end else begin
      cur_state <= nxt_state;
      fcnt      <= nxt_fcnt;
    end
  end

  // NOTE: every output and next-state value gets a default at the top of the
  // block, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    pc_we         = 1'b1;
    ifid_we       = 1'b1;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    exmem_flush   = 1'b0;
    pipe_freeze   = 1'b0;
    nxt_state     = cur_state;
    nxt_fcnt      = fcnt;
    redirect_take = 1'b0;

    unique case (cur_state)
      // LDUSE already inserted its bubble; the load is now in MEM, so luse is moot.
      RUN, LDUSE: begin
        if (wb_redirect) begin
          ifid_flush    = 1'b1;
          idex_bubble   = 1'b1;
          exmem_flush   = 1'b1;
          redirect_take = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            nxt_state = REDIRECT;
            nxt_fcnt  = 2'(FLUSH_CYCLES - 1);
          end else begin
            nxt_state = RUN;
          end
        end else if (mwait) begin
          pipe_freeze = 1'b1;
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          nxt_state   = MEMWAIT;
        end else if (luse && (cur_state == RUN)) begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_bubble = 1'b1;
          nxt_state   = LDUSE;
        end else begin
          nxt_state = RUN;
        end
      end

      // WB is frozen with the rest of the back end, so a redirect cannot retire here.
      MEMWAIT: begin
        if (!dmem_ack) begin
          pipe_freeze = 1'b1;
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
        end else begin
          nxt_state = RUN;
        end
      end

      REDIRECT: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        nxt_fcnt    = fcnt - 2'd1;
        if (fcnt == 2'd1) begin
          nxt_state = RUN;
        end
      end
    endcase

    // During reset the front end is held and every buffer is loaded with a NOP.
    if (!rst_n) begin
      pc_we         = 1'b0;
      ifid_we       = 1'b0;
      ifid_flush    = 1'b1;
      idex_bubble   = 1'b1;
      exmem_flush   = 1'b1;
      pipe_freeze   = 1'b0;
      redirect_take = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_we && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (redirect_take && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule : pipe_hazard_ctrl

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl built with FLUSH_CYCLES=3: a vector table
// for single-cycle decisions plus hand sequences for multi-cycle behaviour.
module tb_pipe_hazard_ctrl;

  localparam int REG_W = 6;
  localparam int FLUSH = 3;
`ifdef HAZARD_PERF_CNT_EN
  localparam int CNT_W = 16;
`endif

  // Output bundle order: {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_flush, pipe_freeze}
  localparam logic [5:0] O_DEF   = 6'b110000;
  localparam logic [5:0] O_LUSE  = 6'b000100;
  localparam logic [5:0] O_FRZ   = 6'b000001;
  localparam logic [5:0] O_REDIR = 6'b111110;
  localparam logic [5:0] O_RFOL  = 6'b111100;
  localparam logic [5:0] O_RST   = 6'b001110;

  logic             clk;
  logic             rst_n;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             ex_memrd;
  logic [REG_W-1:0] ex_rd;
  logic             mem_memrd;
  logic             mem_memwrt;
  logic             dmem_ack;
  logic             wb_redirect;
  logic             pc_we;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             exmem_flush;
  logic             pipe_freeze;
  logic [1:0]       state;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pipe_hazard_ctrl #(
    .REG_W        (REG_W),
    .FLUSH_CYCLES (FLUSH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .ex_memrd    (ex_memrd),
    .ex_rd       (ex_rd),
    .mem_memrd   (mem_memrd),
    .mem_memwrt  (mem_memwrt),
    .dmem_ack    (dmem_ack),
    .wb_redirect (wb_redirect),
    .pc_we       (pc_we),
    .ifid_we     (ifid_we),
    .ifid_flush  (ifid_flush),
    .idex_bubble (idex_bubble),
    .exmem_flush (exmem_flush),
    .pipe_freeze (pipe_freeze),
    .state       (state)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [5:0] rs;
    logic [5:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       ld;
    logic [5:0] rd;
    logic       mrd;
    logic       mwr;
    logic       ack;
    logic       redir;
    logic [5:0] exp_out;
    logic [1:0] exp_state;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic [5:0] rs, logic [5:0] rt, logic urs, logic urt,
                              logic ld, logic [5:0] rd, logic mrd, logic mwr, logic ack,
                              logic redir, logic [5:0] eo, logic [1:0] es);
    vec_t v;
    v.name = n; v.rs = rs; v.rt = rt; v.use_rs = urs; v.use_rt = urt;
    v.ld = ld; v.rd = rd; v.mrd = mrd; v.mwr = mwr; v.ack = ack; v.redir = redir;
    v.exp_out = eo; v.exp_state = es;
    return v;
  endfunction

  function automatic logic [5:0] outs();
    return {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_flush, pipe_freeze};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_memrd = 1'b0; ex_rd = '0; mem_memrd = 1'b0; mem_memwrt = 1'b0;
    dmem_ack = 1'b0; wb_redirect = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    id_rs = v.rs; id_rt = v.rt; id_use_rs = v.use_rs; id_use_rt = v.use_rt;
    ex_memrd = v.ld; ex_rd = v.rd; mem_memrd = v.mrd; mem_memwrt = v.mwr;
    dmem_ack = v.ack; wb_redirect = v.redir;
  endtask

  // Return to RUN with a bounded wait; an acked, idle pipe drains any state.
  task automatic recover(input string name);
    idle();
    dmem_ack = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (state == 2'd0) break;
      tick();
    end
    check({name, "/recover_state"}, 32'(state), 32'd0);
    idle();
  endtask

  initial begin
    int frz;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] f0;
`endif
    idle();
    rst_n = 1'b0;

    //            name         rs  rt  urs urt ld  rd  mrd mwr ack rdr  out      state
    vecs.push_back(mk("idle",      0,  0,  0,  0,  0,  0,  0,  0,  0,  0, O_DEF,   2'd0));
    vecs.push_back(mk("luse_rs",   5,  0,  1,  0,  1,  5,  0,  0,  0,  0, O_LUSE,  2'd1));
    vecs.push_back(mk("luse_rt",   1,  7,  1,  1,  1,  7,  0,  0,  0,  0, O_LUSE,  2'd1));
    vecs.push_back(mk("rs_unused", 5,  0,  0,  0,  1,  5,  0,  0,  0,  0, O_DEF,   2'd0));
    vecs.push_back(mk("r0_nohaz",  0,  0,  1,  1,  1,  0,  0,  0,  0,  0, O_DEF,   2'd0));
    vecs.push_back(mk("not_load",  5,  5,  1,  1,  0,  5,  0,  0,  0,  0, O_DEF,   2'd0));
    vecs.push_back(mk("rd_max",    0, 63,  0,  1,  1, 63,  0,  0,  0,  0, O_LUSE,  2'd1));
    vecs.push_back(mk("mwait_rd",  0,  0,  0,  0,  0,  0,  1,  0,  0,  0, O_FRZ,   2'd2));
    vecs.push_back(mk("mwait_wr",  0,  0,  0,  0,  0,  0,  0,  1,  0,  0, O_FRZ,   2'd2));
    vecs.push_back(mk("mem_acked", 0,  0,  0,  0,  0,  0,  1,  1,  1,  0, O_DEF,   2'd0));
    vecs.push_back(mk("mw_luse",   9,  0,  1,  0,  1,  9,  1,  0,  0,  0, O_FRZ,   2'd2));
    vecs.push_back(mk("redirect",  0,  0,  0,  0,  0,  0,  0,  0,  0,  1, O_REDIR, 2'd3));
    vecs.push_back(mk("rd_all",    9,  0,  1,  0,  1,  9,  1,  0,  0,  1, O_REDIR, 2'd3));

    // Reset held for three cycles, with hazards driven to show they are masked.
    wb_redirect = 1'b1; mem_memrd = 1'b1;
    repeat (3) tick();
    check("rst_outs", 32'(outs()), 32'(O_RST));
    check("rst_state", 32'(state), 32'd0);
    idle();
    rst_n = 1'b1;
    #1;
    check("rel_outs", 32'(outs()), 32'(O_DEF));
    tick();
    check("rel_state", 32'(state), 32'd0);

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #1;
      check({vecs[i].name, "/outs"}, 32'(outs()), 32'(vecs[i].exp_out));
      tick();
      check({vecs[i].name, "/state"}, 32'(state), 32'(vecs[i].exp_state));
      recover(vecs[i].name);
    end

    // Load-use: one bubble, then LDUSE ignores a still-matching compare.
    drive(vecs[1]);
    #1;
    check("lu_seq_c0", 32'(outs()), 32'(O_LUSE));
    tick();
    check("lu_seq_st1", 32'(state), 32'd1);
    #1;
    check("lu_seq_c1", 32'(outs()), 32'(O_DEF));
    ex_memrd = 1'b0;
    tick();
    check("lu_seq_st2", 32'(state), 32'd0);
    #1;
    check("lu_seq_c2", 32'(outs()), 32'(O_DEF));
    idle();

    // Memory wait: four unacked cycles freeze, a redirect inside is ignored.
    frz = 0;
    mem_memrd = 1'b1;
    for (int c = 0; c < 4; c++) begin
      wb_redirect = (c == 2);
      #1;
      if (pipe_freeze) frz++;
      if (c == 2) check("mw_redir_ign", 32'(outs()), 32'(O_FRZ));
      tick();
      check("mw_state", 32'(state), 32'd2);
    end
    wb_redirect = 1'b0;
    check("mw_frz_cycles", 32'(frz), 32'd4);
    dmem_ack = 1'b1;
    #1;
    check("mw_ack_outs", 32'(outs()), 32'(O_DEF));
    tick();
    check("mw_ack_state", 32'(state), 32'd0);
    idle();

    // Redirect with three flush cycles; a second redirect in REDIRECT is dropped.
    wb_redirect = 1'b1;
    #1;
    check("rd_c0", 32'(outs()), 32'(O_REDIR));
    tick();
    check("rd_st1", 32'(state), 32'd3);
    #1;
    check("rd_c1", 32'(outs()), 32'(O_RFOL));
    tick();
    wb_redirect = 1'b0;
    check("rd_st2", 32'(state), 32'd3);
    #1;
    check("rd_c2", 32'(outs()), 32'(O_RFOL));
    tick();
    check("rd_st3", 32'(state), 32'd0);
    #1;
    check("rd_c3", 32'(outs()), 32'(O_DEF));
    tick();
    check("rd_st4", 32'(state), 32'd0);

`ifdef HAZARD_PERF_CNT_EN
    f0 = flush_cnt;
    drive(vecs[12]);
    tick();
    check("perf_flush", 32'(flush_cnt), 32'(f0 + CNT_W'(1)));
    recover("perf");
`endif

    // Asynchronous reset in MEMWAIT returns to RUN without waiting for a clock.
    mem_memwrt = 1'b1;
    tick();
    check("ar_pre_state", 32'(state), 32'd2);
    rst_n = 1'b0;
    #1;
    check("ar_state", 32'(state), 32'd0);
    check("ar_outs", 32'(outs()), 32'(O_RST));
    idle();
    tick();
    rst_n = 1'b1;
    #1;
    check("ar_rel_outs", 32'(outs()), 32'(O_DEF));
    tick();
    check("ar_rel_state", 32'(state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pipe_hazard_ctrl

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline.
- Owns the write enables of the PC and IF/ID buffer.
- Drives bubble/flush controls into the ID/EX and EX/MEM buffers.
- Resolves three hazard classes with a small FSM, in fixed priority: late-resolved branch/jump redirect, data-memory wait, and load-use.

Parameters:
REG_W, 6, register index width (matches ID/EX rd field)
FLUSH_CYCLES, 1, cycles of IF/ID + ID/EX flush after a redirect; legal range 1..3
CNT_W, 16, width of performance counters (optional feature only)

Ports:
clk  in  1  pipeline clock; all state updates on posedge
rst_n  in  1  reset; asynchronous, active-low
id_rs  in  REG_W  rs index of instruction in ID
id_rt  in  REG_W  rt index of instruction in ID
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
ex_memrd  in  1  ID/EX buffered memrd control (EX holds a load)
ex_rd  in  REG_W  ID/EX buffered destination index
mem_memrd  in  1  EX/MEM memrd (MEM stage access active)
mem_memwrt  in  1  EX/MEM memwrt
dmem_ack  in  1  data memory completes access this cycle
wb_redirect  in  1  branch taken or jump resolved in WB; PC target valid
pc_we  out  1  PC register write enable
ifid_we  out  1  IF/ID buffer write enable
ifid_flush  out  1  load NOP into IF/ID
idex_bubble  out  1  zero all ID/EX control fields (regwrt, memrd, memwrt, branch, jump)
exmem_flush  out  1  zero EX/MEM control fields
pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB contents
state  out  2  current FSM state (debug)

Behaviour:
- Outputs are Mealy: a combinational function of the registered state and the current inputs. State and counters are registered on posedge clk.
- States: RUN=0, LDUSE=1, MEMWAIT=2, REDIRECT=3. Internal flush counter fcnt is 2 bits.
- Reset (rst_n low, asynchronous):
  - state=RUN, fcnt=0.
  - Outputs forced: pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, exmem_flush=1, pipe_freeze=0.
- Default outputs (no hazard): pc_we=1, ifid_we=1, all flush/bubble/freeze=0.
- Load-use hit (luse) = ex_memrd & (ex_rd!=0) & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)). Index 0 is hardwired zero and never hazards.
- Memory wait (mwait) = (mem_memrd | mem_memwrt) & !dmem_ack.
- RUN, evaluated in priority order:
  1. wb_redirect:
     - Outputs: ifid_flush=1, idex_bubble=1, exmem_flush=1, pc_we=1.
     - Next: if FLUSH_CYCLES>1, go REDIRECT with fcnt=FLUSH_CYCLES-1; else stay RUN.
  2. mwait:
     - Outputs: pipe_freeze=1, pc_we=0, ifid_we=0.
     - Next: MEMWAIT.
  3. luse:
     - Outputs: pc_we=0, ifid_we=0, idex_bubble=1.
     - Next: LDUSE.
  4. Otherwise: default outputs, stay RUN.
- LDUSE: exactly one bubble has already been inserted. Re-evaluate with RUN priority, except luse is ignored (the load has moved to MEM). Next state follows the RUN rules.
- MEMWAIT:
  - While !dmem_ack: pipe_freeze=1, pc_we=0, ifid_we=0. wb_redirect is ignored (WB is frozen).
  - On dmem_ack: default outputs, next RUN.
- REDIRECT:
  - Outputs: ifid_flush=1, idex_bubble=1, pc_we=1, ifid_we=1.
  - fcnt decrements each cycle; when fcnt==1, next RUN.
  - wb_redirect is ignored here (the older instruction was already flushed).
- Simultaneous events: redirect beats mwait beats luse. A mwait on the same cycle as a redirect is dropped, because exmem_flush kills that access.
- Reset mid-operation: returns immediately to RUN with fcnt cleared. No pending stall survives reset.

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cnt [CNT_W] (cycles with pc_we=0 while rst_n high) and flush_cnt [CNT_W] (RUN-state redirect events).
  - Both counters saturate at all-ones and clear on reset.
- Undefined: the ports and counters do not exist; the rest of the behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - state enum hz_state_t {RUN, LDUSE, MEMWAIT, REDIRECT}
  - REG_W default
  - constant ZERO_REG=0
- One sub-module, hz_luse_cmp: the combinational load-use comparator producing luse. It is reused later by the forwarding unit.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> pc_we=0, idex_bubble=1, ifid_flush=1, exmem_flush=1, state=0. Release -> pc_we=1, state=0.
- Load-use: ex_memrd=1, ex_rd=5, id_rs=5, id_use_rs=1 -> one cycle pc_we=0, ifid_we=0, idex_bubble=1, then state=1. Next cycle with ex_memrd=0 -> defaults.
- No hazard on r0: ex_memrd=1, ex_rd=0, id_rs=0, id_use_rs=1 -> no stall, state stays 0.
- Memory wait: mem_memrd=1, dmem_ack=0 for 4 cycles, then dmem_ack=1 -> pipe_freeze=1 for exactly 4 cycles, state=2, back to RUN after the ack cycle.
- Redirect with FLUSH_CYCLES=3: wb_redirect pulse -> ifid_flush=1 for 3 consecutive cycles, exmem_flush=1 on the first only. A second wb_redirect during REDIRECT is ignored.
- Priority: wb_redirect=1, mwait=1 and luse=1 together -> redirect outputs only, pipe_freeze=0. With HAZARD_PERF_CNT_EN, flush_cnt increments by 1.
